// File: rtl/md_unit_pkg.sv
// Shared opcode encoding, result types and arithmetic helpers for the multiply/divide unit.
// Imported by the interface, the unit itself and any decoder or forwarding logic that names MD ops.
package md_unit_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_OP_MULT  = 4'd0,
        MD_OP_MULTU = 4'd1,
        MD_OP_DIV   = 4'd2,
        MD_OP_DIVU  = 4'd3,
        MD_OP_MTHI  = 4'd4,
        MD_OP_MTLO  = 4'd5,
        MD_OP_MFHI  = 4'd6,
        MD_OP_MFLO  = 4'd7,
        MD_OP_MADD  = 4'd8,
        MD_OP_MADDU = 4'd9,
        MD_OP_MSUB  = 4'd10,
        MD_OP_MSUBU = 4'd11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_pair_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // The low 64 bits of a product of sign- or zero-extended operands equal the
    // signed or unsigned 32x32 product, so one multiplier serves both flavours.
    function automatic logic [63:0] md_product(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        sgn);
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        ext_a = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ext_a * ext_b;
    endfunction

    // Division on magnitudes, then sign fix-up: quotient truncates toward zero,
    // remainder follows the dividend. 0x8000_0000 / -1 wraps back to 0x8000_0000.
    function automatic md_pair_t md_divide(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
        md_pair_t    res;
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quot;
        logic [31:0] rem;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (b == 32'd0) begin
            res.lo = 32'hFFFF_FFFF;
            res.hi = a;
        end else begin
            quot   = mag_a / mag_b;
            rem    = mag_a % mag_b;
            res.lo = (neg_a ^ neg_b) ? (32'd0 - quot) : quot;
            res.hi = neg_a ? (32'd0 - rem) : rem;
        end
        return res;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage operand/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface md_unit_if;

    logic                            op_valid;
    logic [md_unit_pkg::MD_OP_W-1:0] md_op;
    logic [31:0]                     a;
    logic [31:0]                     b;
    logic                            busy;
    logic [31:0]                     md_out;
    logic [31:0]                     hi;
    logic [31:0]                     lo;

    modport master (
        output op_valid, md_op, a, b,
        input  busy, md_out, hi, lo
    );

    modport slave (
        input  op_valid, md_op, a, b,
        output busy, md_out, hi, lo
    );

endinterface

// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit holding the architectural HI/LO registers.
// Define MD_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops; undefined, they decode as no-ops.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset_n,
    md_unit_if.slave md
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    md_state_e          state_reg;
    md_state_e          state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    md_pair_t           pend_reg;
    md_pair_t           pend_next;
    logic [31:0]        hi_reg;
    logic [31:0]        hi_next;
    logic [31:0]        lo_reg;
    logic [31:0]        lo_next;

    logic               op_mul;
    logic               op_div;
    logic               op_sgn;
    logic               op_mthi;
    logic               op_mtlo;
`ifdef MD_MADD_EN
    logic               op_acc;
    logic               op_sub;
`endif
    logic               busy_reg;
    logic               accept;
    logic               start;
    logic [63:0]        product;
    md_pair_t           quotient;
    md_pair_t           start_result;
    logic [CNT_W-1:0]   start_count;

    always_comb begin
        op_mul  = 1'b0;
        op_div  = 1'b0;
        op_sgn  = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
`ifdef MD_MADD_EN
        op_acc  = 1'b0;
        op_sub  = 1'b0;
`endif
        case (md.md_op)
            MD_OP_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
            MD_OP_MULTU: begin op_mul = 1'b1; end
            MD_OP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
            MD_OP_DIVU:  begin op_div = 1'b1; end
            MD_OP_MTHI:  begin op_mthi = 1'b1; end
            MD_OP_MTLO:  begin op_mtlo = 1'b1; end
`ifdef MD_MADD_EN
            MD_OP_MADD:  begin op_mul = 1'b1; op_acc = 1'b1; op_sgn = 1'b1; end
            MD_OP_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
            MD_OP_MSUB:  begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; op_sgn = 1'b1; end
            MD_OP_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign busy_reg    = (state_reg == ST_RUN);
    assign accept      = md.op_valid & ~busy_reg;
    assign start       = accept & (op_mul | op_div);
    assign product     = md_product(md.a, md.b, op_sgn);
    assign quotient    = md_divide(md.a, md.b, op_sgn);
    assign start_count = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // The result is captured at the start edge, so the accumulate sees HI/LO as
    // they stand then, and later operand changes in E cannot disturb it.
    always_comb begin
        start_result = op_div ? quotient : md_pair_t'(product);
`ifdef MD_MADD_EN
        if (op_acc) begin
            start_result = op_sub ? md_pair_t'({hi_reg, lo_reg} - product)
                                  : md_pair_t'({hi_reg, lo_reg} + product);
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        pend_next  = pend_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    count_next = start_count;
                    pend_next  = start_result;
                end else if (accept && op_mthi) begin
                    hi_next = md.a;
                end else if (accept && op_mtlo) begin
                    lo_next = md.a;
                end
            end
            ST_RUN: begin
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    hi_next    = pend_reg.hi;
                    lo_next    = pend_reg.lo;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            pend_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            pend_reg  <= pend_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // Busy covers the start cycle itself so a following MD op in D stalls at once.
    assign md.busy = start | busy_reg;
    assign md.hi   = hi_reg;
    assign md.lo   = lo_reg;

    always_comb begin
        md.md_out = 32'd0;
        case (md.md_op)
            MD_OP_MFHI: md.md_out = hi_reg;
            MD_OP_MFLO: md.md_out = lo_reg;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit plus hand-written multi-cycle sequences.
// Honours MD_MADD_EN the same way the design does.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    md_unit_if bus();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus)
    );

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one op for a single cycle, then count cycles busy stays high (bounded).
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output logic start_busy, output int cycles);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = op;
        bus.a        = a;
        bus.b        = b;
        #1 start_busy = bus.busy;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.md_op    = 4'hF;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        $display("[TB] op=%s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d",
                 op.name(), a, b, bus.hi, bus.lo, cycles);
    endtask

    task automatic write_mt(input md_op_e op, input logic [31:0] val);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = op;
        bus.a        = val;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.md_op    = 4'hF;
        $display("[TB] op=%s a=%h -> hi=%h lo=%h", op.name(), val, bus.hi, bus.lo);
    endtask

    initial begin
        logic sb;
        int   cyc;

        vecs[0]  = '{MD_OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N};
        vecs[1]  = '{MD_OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
        vecs[2]  = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        vecs[3]  = '{MD_OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, DIV_N};
        vecs[4]  = '{MD_OP_DIV,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, DIV_N};
        vecs[5]  = '{MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
        vecs[6]  = '{MD_OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, DIV_N};
        vecs[7]  = '{MD_OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MULT_N};
        vecs[8]  = '{MD_OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N};
        vecs[9]  = '{MD_OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MULT_N};
        vecs[10] = '{MD_OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, DIV_N};
        vecs[11] = '{MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N};

        bus.op_valid = 1'b0;
        bus.md_op    = 4'hF;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_hi",   bus.hi, 32'd0);
        check32("reset_lo",   bus.lo, 32'd0);
        check32("reset_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, sb, cyc);
            check32($sformatf("v%0d_start_busy", i), {31'd0, sb}, 32'd1);
            check32($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cycles);
            check32($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
            check32($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
        end

        // MTHI while a MULT is in flight must be ignored.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = MD_OP_MULT;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = MD_OP_MTHI;
        bus.a        = 32'hAAAA_0000;
        #1 check32("mthi_in_flight_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.md_op    = 4'hF;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        $display("[TB] op=MULT a=3 b=5 with MTHI in flight -> hi=%h lo=%h", bus.hi, bus.lo);
        check32("mthi_ignored_hi", bus.hi, 32'h0000_0000);
        check32("mthi_ignored_lo", bus.lo, 32'h0000_000F);

        // MTHI/MTLO when idle, then MFHI/MFLO read back.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = MD_OP_MTHI;
        bus.a        = 32'hAAAA_0000;
        #1 check32("mthi_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 check32("mthi_hi", bus.hi, 32'hAAAA_0000);
        bus.op_valid = 1'b0;
        $display("[TB] op=MD_OP_MTHI a=aaaa0000 -> hi=%h lo=%h", bus.hi, bus.lo);
        write_mt(MD_OP_MTLO, 32'h1234_5678);
        check32("mtlo_lo", bus.lo, 32'h1234_5678);
        check32("mtlo_keeps_hi", bus.hi, 32'hAAAA_0000);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = MD_OP_MFHI;
        #1 check32("mfhi_out", bus.md_out, 32'hAAAA_0000);
        @(negedge clk);
        bus.md_op = MD_OP_MFLO;
        #1 check32("mflo_out", bus.md_out, 32'h1234_5678);
        @(negedge clk);
        bus.md_op = MD_OP_MTLO;
        bus.a     = 32'd0;
        #1 check32("mt_out_zero", bus.md_out, 32'd0);
        bus.op_valid = 1'b0;
        $display("[TB] MFHI/MFLO read-back done");

        // Unlisted opcode: no start, no register change.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = 4'hD;
        bus.a        = 32'h5555_5555;
        bus.b        = 32'h3;
        #1 check32("noop_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.md_op    = 4'hF;
        check32("noop_hi", bus.hi, 32'hAAAA_0000);
        check32("noop_lo", bus.lo, 32'h1234_5678);
        $display("[TB] op=0xD (no-op) -> hi=%h lo=%h", bus.hi, bus.lo);

        // Reset in the middle of a MULT aborts it.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.md_op    = MD_OP_MULT;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h2;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.md_op    = 4'hF;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check32("abort_hi",   bus.hi, 32'd0);
        check32("abort_lo",   bus.lo, 32'd0);
        check32("abort_busy", {31'd0, bus.busy}, 32'd0);
        $display("[TB] reset mid-MULT -> hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (MULT_N + 2) @(posedge clk);
        #1;
        check32("abort_no_late_hi", bus.hi, 32'd0);
        check32("abort_no_late_lo", bus.lo, 32'd0);
        issue(MD_OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, sb, cyc);
        check32("post_reset_cycles", cyc, MULT_N);
        check32("post_reset_hi", bus.hi, 32'hFFFF_FFFF);
        check32("post_reset_lo", bus.lo, 32'hFFFF_FFEB);

        // Multiply-accumulate.
        write_mt(MD_OP_MTHI, 32'h0000_0000);
        write_mt(MD_OP_MTLO, 32'hFFFF_FFFF);
        issue(MD_OP_MADDU, 32'd1, 32'd1, sb, cyc);
`ifdef MD_MADD_EN
        check32("maddu_start_busy", {31'd0, sb}, 32'd1);
        check32("maddu_cycles", cyc, MULT_N);
        check32("maddu_hi", bus.hi, 32'h0000_0001);
        check32("maddu_lo", bus.lo, 32'h0000_0000);
        issue(MD_OP_MSUB, 32'd1, 32'd2, sb, cyc);
        check32("msub_cycles", cyc, MULT_N);
        check32("msub_hi", bus.hi, 32'h0000_0000);
        check32("msub_lo", bus.lo, 32'hFFFF_FFFE);
`else
        check32("maddu_start_busy", {31'd0, sb}, 32'd0);
        check32("maddu_cycles", cyc, 0);
        check32("maddu_hi", bus.hi, 32'h0000_0000);
        check32("maddu_lo", bus.lo, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
